vga_demo_plotter: RTL and testbench

Board-level demo top for the DE1-SoC that plots single coloured pixels on a VGA monitor. The operator latches X from the switches, latches Y, then presses the plot key to write a 3-bit colour into an on-chip 160×120 frame buffer. A built-in 640×480@60 Hz scan-out engine displays each buffer pixel as a 4×4 block. The HEX displays echo the latched coordinates.

---
 rtl/vga_demo_plotter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vga_demo_plotter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_demo_plotter.sv
`default_nettype none
// ============================================================================
// Module   : vga_demo_plotter
// Purpose  : DE1-SoC demo top. The operator latches X and Y from the switches,
//            then plots a 3-bit colour into a 160x120 frame buffer. The buffer
//            is scanned out at 640x480@60Hz, with each buffer pixel shown as a
//            4x4 block. HEX3:HEX2 echo X and HEX1:HEX0 echo Y.
// Ports    : CLOCK_50        50 MHz clock (the only clock)
//            KEY[0]          asynchronous active-low reset
//            KEY[3:1]        active-low keys: load X, load Y, plot
//            SW[9:0]         data switches
//            HEX3..HEX0      seven-segment digits, active-low {g..a}
//            VGA_R/G/B       8-bit colour channels
//            VGA_HS/VGA_VS   active-low sync
//            VGA_BLANK_N     high in the visible area
//            VGA_SYNC_N      tied low
//            VGA_CLK         25 MHz pixel clock (toggle flop)
// Options  : VGA_DEMO_CLEAR_EN -- when defined, the frame buffer is cleared
//            after every reset and keys are ignored until the clear is done.
// Revision : 1.0 - initial release
// ============================================================================
module vga_demo_plotter (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int          c_FB_DEPTH   = 19200;
    localparam logic [9:0]  c_H_VISIBLE  = 10'd640;
    localparam logic [9:0]  c_H_SYNC_BEG = 10'd656;
    localparam logic [9:0]  c_H_SYNC_END = 10'd752;
    localparam logic [9:0]  c_H_LAST     = 10'd799;
    localparam logic [9:0]  c_V_VISIBLE  = 10'd480;
    localparam logic [9:0]  c_V_SYNC_BEG = 10'd490;
    localparam logic [9:0]  c_V_SYNC_END = 10'd492;
    localparam logic [9:0]  c_V_LAST     = 10'd524;

    logic w_rst_n;
    assign w_rst_n = KEY[0];

    // SW[9:8] carry no function in this demo.
    logic w_unused_sw;
    assign w_unused_sw = &{1'b0, SW[9:8]};

    // ------------------------------------------------------------------------
    // Key synchroniser and falling-edge detector. All flops reset to the
    // released level so a pulse in flight is discarded by reset.
    // ------------------------------------------------------------------------
    logic [2:0] r_key_s1, r_key_s2, r_key_d;
    logic [2:0] w_press;
    logic       w_clearing;
    logic [14:0] w_clr_addr;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_s1 <= 3'b111;
            r_key_s2 <= 3'b111;
            r_key_d  <= 3'b111;
        end else begin
            r_key_s1 <= KEY[3:1];
            r_key_s2 <= r_key_s1;
            r_key_d  <= r_key_s2;
        end
    end

    assign w_press = r_key_d & ~r_key_s2 & {3{~w_clearing}};

`ifdef VGA_DEMO_CLEAR_EN
    // ------------------------------------------------------------------------
    // Post-reset clear: one zero write per clock across the whole buffer.
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;
    state_t      r_state, w_state_next;
    logic [14:0] r_clr_addr;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= 15'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR)
                r_clr_addr <= r_clr_addr + 15'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clearing   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clearing = 1'b1;
                if (r_clr_addr == 15'(c_FB_DEPTH - 1))
                    w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    assign w_clr_addr = r_clr_addr;
`else
    assign w_clearing = 1'b0;
    assign w_clr_addr = 15'd0;
`endif

    // ------------------------------------------------------------------------
    // Coordinate / colour registers and plot port. A coordinate loaded in
    // the same cycle as a plot is used for that plot's address.
    // ------------------------------------------------------------------------
    logic [7:0]  r_x, w_x_new;
    logic [6:0]  r_y, w_y_new;
    logic [2:0]  r_colour;
    logic [14:0] w_plot_addr;
    logic        w_plot_ok;
    logic        w_we;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
        end else begin
            if (w_press[0]) r_x      <= SW[7:0];
            if (w_press[1]) r_y      <= SW[6:0];
            if (w_press[2]) r_colour <= SW[2:0];
        end
    end

    assign w_x_new     = w_press[0] ? SW[7:0] : r_x;
    assign w_y_new     = w_press[1] ? SW[6:0] : r_y;
    assign w_plot_addr = 15'(w_y_new) * 15'd160 + 15'(w_x_new);
    assign w_plot_ok   = w_press[2] && (w_x_new < 8'd160) && (w_y_new < 7'd120);

    assign w_we    = w_clearing | w_plot_ok;
    assign w_waddr = w_clearing ? w_clr_addr : w_plot_addr;
    assign w_wdata = w_clearing ? 3'd0 : SW[2:0];

    // ------------------------------------------------------------------------
    // Pixel clock and scan counters. The enable fires on the edge where
    // VGA_CLK rises.
    // ------------------------------------------------------------------------
    logic       r_vga_clk;
    logic       w_pix_en;
    logic [9:0] r_h, r_v;

    assign w_pix_en = ~r_vga_clk;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vga_clk <= 1'b0;
            r_h       <= 10'd0;
            r_v       <= 10'd0;
        end else begin
            r_vga_clk <= ~r_vga_clk;
            if (w_pix_en) begin
                if (r_h == c_H_LAST) begin
                    r_h <= 10'd0;
                    r_v <= (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    logic        w_vis, w_hs, w_vs;
    logic [14:0] w_rd_addr;

    assign w_vis     = (r_h < c_H_VISIBLE) && (r_v < c_V_VISIBLE);
    assign w_hs      = ~((r_h >= c_H_SYNC_BEG) && (r_h < c_H_SYNC_END));
    assign w_vs      = ~((r_v >= c_V_SYNC_BEG) && (r_v < c_V_SYNC_END));
    assign w_rd_addr = 15'(r_v[9:2]) * 15'd160 + 15'(r_h[9:2]);

    // ------------------------------------------------------------------------
    // Frame buffer: plot/clear write port, scan-out read port. Contents are
    // deliberately not reset. The read is gated outside the visible area
    // where the computed address would exceed the buffer.
    // ------------------------------------------------------------------------
    logic [2:0] r_mem [0:c_FB_DEPTH-1];
    logic [2:0] r_rd_data;

    always_ff @(posedge CLOCK_50) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (w_pix_en)
            r_rd_data <= w_vis ? r_mem[w_rd_addr] : 3'd0;
    end

    // Sync/blank stage matching the RAM read latency, then output registers.
    logic r_hs_d1, r_vs_d1, r_vis_d1;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b1;
            r_vis_d1    <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
        end else if (w_pix_en) begin
            r_hs_d1     <= w_hs;
            r_vs_d1     <= w_vs;
            r_vis_d1    <= w_vis;
            VGA_HS      <= r_hs_d1;
            VGA_VS      <= r_vs_d1;
            VGA_BLANK_N <= r_vis_d1;
            VGA_R       <= r_vis_d1 ? {8{r_rd_data[2]}} : 8'd0;
            VGA_G       <= r_vis_d1 ? {8{r_rd_data[1]}} : 8'd0;
            VGA_B       <= r_vis_d1 ? {8{r_rd_data[0]}} : 8'd0;
        end
    end

    assign VGA_CLK    = r_vga_clk;
    assign VGA_SYNC_N = 1'b0;

    // ------------------------------------------------------------------------
    // Seven-segment echo of the latched coordinates.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_hex7(input logic [3:0] d);
        case (d)
            4'h0: f_hex7 = 7'b1000000;
            4'h1: f_hex7 = 7'b1111001;
            4'h2: f_hex7 = 7'b0100100;
            4'h3: f_hex7 = 7'b0110000;
            4'h4: f_hex7 = 7'b0011001;
            4'h5: f_hex7 = 7'b0010010;
            4'h6: f_hex7 = 7'b0000010;
            4'h7: f_hex7 = 7'b1111000;
            4'h8: f_hex7 = 7'b0000000;
            4'h9: f_hex7 = 7'b0010000;
            4'hA: f_hex7 = 7'b0001000;
            4'hB: f_hex7 = 7'b0000011;
            4'hC: f_hex7 = 7'b1000110;
            4'hD: f_hex7 = 7'b0100001;
            4'hE: f_hex7 = 7'b0000110;
            default: f_hex7 = 7'b0001110;
        endcase
    endfunction

    assign HEX3 = f_hex7(r_x[7:4]);
    assign HEX2 = f_hex7(r_x[3:0]);
    assign HEX1 = f_hex7({1'b0, r_y[6:4]});
    assign HEX0 = f_hex7(r_y[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_vga_demo_plotter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_demo_plotter
// Purpose  : Directed self-checking bench for vga_demo_plotter: reset state,
//            key loads and plots, scan-out of a plotted block, line timing,
//            out-of-range plot suppression and mid-line reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_demo_plotter;

    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;

    localparam logic [6:0] c_SEG0 = 7'b1000000;
    localparam logic [6:0] c_SEG3 = 7'b0110000;
    localparam logic [6:0] c_SEG4 = 7'b0011001;
    localparam logic [6:0] c_SEG5 = 7'b0010010;
    localparam logic [6:0] c_SEG7 = 7'b1111000;
    localparam logic [6:0] c_SEG8 = 7'b0000000;
    localparam logic [6:0] c_SEGC = 7'b1000110;
    localparam logic [6:0] c_SEGF = 7'b0001110;

    int total = 0;
    int bad   = 0;
    int cur_line = 0;
    int cur_px   = 0;

    vga_demo_plotter dut (
        .CLOCK_50   (CLOCK_50),
        .KEY        (KEY),
        .SW         (SW),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_CLK    (VGA_CLK)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse the selected keys (bit0=KEY[1], bit1=KEY[2], bit2=KEY[3]) low
    // for one cycle, then allow the write to settle.
    task automatic press(input logic [2:0] k);
        @(negedge CLOCK_50);
        KEY[3:1] = ~k;
        @(negedge CLOCK_50);
        KEY[3:1] = 3'b111;
        repeat (5) @(negedge CLOCK_50);
    endtask

    // Advance to the first visible-pixel sample of the next line; returns the
    // number of cycles spent and of HS/VS-low samples seen on the way.
    task automatic next_line(output int cycles, output int hs_low, output int vs_low);
        logic prev;
        logic found;
        prev   = VGA_BLANK_N;
        found  = 1'b0;
        cycles = 0;
        hs_low = 0;
        vs_low = 0;
        while (!found && cycles < 4000) begin
            @(negedge CLOCK_50);
            cycles++;
            if (!VGA_HS) hs_low++;
            if (!VGA_VS) vs_low++;
            if (!prev && VGA_BLANK_N) found = 1'b1;
            prev = VGA_BLANK_N;
        end
        if (!found) chk("line_timeout", 32'd0, 32'd1);
        cur_line++;
        cur_px = 0;
    endtask

    task automatic goto_px(input int line, input int px);
        int c, h, v;
        while (cur_line < line) next_line(c, h, v);
        repeat (2 * (px - cur_px)) @(negedge CLOCK_50);
        cur_px = px;
    endtask

    initial begin
        int cyc, hsl, vsl;
        realtime t0, t1;
        KEY = 4'b1110;
        SW  = 10'd0;

        // ---------------- reset state ----------------
        repeat (4) @(negedge CLOCK_50);
        chk("rst_hs",    VGA_HS, 1);
        chk("rst_vs",    VGA_VS, 1);
        chk("rst_blank", VGA_BLANK_N, 0);
        chk("rst_rgb",   {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_hex",   {HEX3, HEX2, HEX1, HEX0}, {c_SEG0, c_SEG0, c_SEG0, c_SEG0});
        chk("rst_sync_n", VGA_SYNC_N, 0);
        chk("rst_vgaclk", VGA_CLK, 0);
        KEY[0] = 1'b1;

        // ---------------- plot (4,4) in red ----------------
        SW = 10'b100;
        press(3'b001);
        press(3'b010);
        press(3'b100);
        chk("hex_x4", {HEX3, HEX2}, {c_SEG0, c_SEG4});
        chk("hex_y4", {HEX1, HEX0}, {c_SEG0, c_SEG4});
        chk("ram644", dut.r_mem[644], 3'b100);

        // ---------------- scan-out of block at (16..19,16..19) ----------------
        goto_px(15, 16);
        chk("l15_p16_r", VGA_R, 8'h00);
        goto_px(16, 15);
        chk("l16_p15_r", VGA_R, 8'h00);
        for (int p = 16; p < 20; p++) begin
            goto_px(16, p);
            chk("l16_r", VGA_R, 8'hFF);
            chk("l16_gb", {VGA_G, VGA_B}, 16'h0000);
            chk("l16_blank", VGA_BLANK_N, 1);
        end
        goto_px(16, 20);
        chk("l16_p20_r", VGA_R, 8'h00);
        goto_px(19, 17);
        chk("l19_p17_r", VGA_R, 8'hFF);
        goto_px(20, 17);
        chk("l20_p17_r", VGA_R, 8'h00);
        chk("vs_high", VGA_VS, 1);

        // ---------------- line timing ----------------
        next_line(cyc, hsl, vsl);
        next_line(cyc, hsl, vsl);
        chk("line_cycles", cyc, 1600);
        chk("hs_low_px", hsl / 2, 96);
        chk("vs_low_l21", vsl, 0);
        @(posedge VGA_CLK);
        t0 = $realtime;
        @(posedge VGA_CLK);
        t1 = $realtime;
        chk("vgaclk_ns", int'(t1 - t0), 40);

        // ---------------- out-of-range X ----------------
        SW = 10'd200;
        press(3'b001);
        chk("hex_xc8", {HEX3, HEX2}, {c_SEGC, c_SEG8});
        SW = 10'd7;
        press(3'b100);
        chk("ram840_untouched", dut.r_mem[840], 3'b000);
        chk("ram644_kept", dut.r_mem[644], 3'b100);

        SW = 10'd127;
        press(3'b010);
        chk("hex_y7f", {HEX1, HEX0}, {c_SEG7, c_SEGF});

        // ---------------- simultaneous press uses new X/Y ----------------
        SW = 10'd5;
        press(3'b111);
        chk("hex_sim", {HEX3, HEX2, HEX1, HEX0}, {c_SEG0, c_SEG5, c_SEG0, c_SEG5});
        chk("ram805", dut.r_mem[805], 3'b101);

        // ---------------- mid-line reset ----------------
        repeat (37) @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #3 KEY[0] = 1'b0;
        #2;
        chk("mrst_hs",    VGA_HS, 1);
        chk("mrst_vs",    VGA_VS, 1);
        chk("mrst_blank", VGA_BLANK_N, 0);
        chk("mrst_rgb",   {VGA_R, VGA_G, VGA_B}, 0);
        chk("mrst_vgaclk", VGA_CLK, 0);
        chk("mrst_hex",   {HEX3, HEX2, HEX1, HEX0}, {c_SEG0, c_SEG0, c_SEG0, c_SEG0});
        @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        SW = 10'd7;
        press(3'b100);
        chk("ram0_after_rst", dut.r_mem[0], 3'b111);

        // ---------------- held key does not repeat ----------------
        SW = 10'd3;
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        SW = 10'd9;
        repeat (6) @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("hold_x3", HEX2, c_SEG3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
